// File: rtl/cpu_trace_fifo.sv
// Instruction trace FIFO fed by the core observer bus (jp, ip, cmd).
// Optional capture trigger on TRIG_IP: define TRACE_TRIGGER_EN.
module cpu_trace_fifo #(
  parameter int          AW      = 4,
  parameter logic [15:0] TRIG_IP = 16'h0000
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   i_jp,
  input  logic [15:0]   i_ip,
  input  logic [15:0]   i_cmd,
  input  logic          i_en,
  input  logic          i_clr,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [31:0]   o_data,
  output logic [AW:0]   o_count,
  output logic          o_overflow,
  output logic [15:0]   o_drop_cnt
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic [15:0] jp_prev_q;
  logic        ovf_q, ovf_d;
  logic [15:0] drop_q, drop_d;

  logic        cap_evt;
  logic        cap;
  logic        empty;
  logic        full;
  logic        rd;
  logic        wr_en;
  logic        drop;

  assign cap_evt = i_en && (i_jp == 16'd1)
                   && (jp_prev_q != 16'd1);

`ifdef TRACE_TRIGGER_EN
  logic trig_q, trig_d;
  logic trig_hit;

  assign trig_hit = cap_evt && (i_ip == TRIG_IP);
  assign cap      = cap_evt && (trig_q || trig_hit);

  // Trigger latches on the first matching fetch; clear re-arms it.
  always_comb begin
    trig_d = trig_q | trig_hit;
    if (i_clr) trig_d = 1'b0;
  end

  // Triggered-state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) trig_q <= 1'b0;
    else       trig_q <= trig_d;
  end
`else
  logic unused_trig_ip;
  assign unused_trig_ip = ^TRIG_IP;
  assign cap = cap_evt;
`endif

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW])
                 && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rd    = !empty && i_ready;
  assign wr_en = cap && (!full || rd) && !i_clr;
  assign drop  = cap && full && !rd && !i_clr;

  // Pointer, overflow flag and drop counter next state.
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (i_clr) begin
      wr_d   = '0;
      rd_d   = '0;
      ovf_d  = 1'b0;
      drop_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + 1'b1;
      if (rd)    rd_d = rd_q + 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF)
          drop_d = drop_q + 16'd1;
      end
    end
  end

  // Control state with async reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q      <= '0;
      rd_q      <= '0;
      jp_prev_q <= '0;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      jp_prev_q <= i_jp;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  // Entry storage; contents survive reset, only pointers matter.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= {i_ip, i_cmd};
  end

  assign o_valid    = !empty;
  assign o_data     = empty ? 32'd0 : mem_q[rd_q[AW-1:0]];
  assign o_count    = wr_q - rd_q;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_cpu_trace_fifo.sv
// Directed self-checking bench for cpu_trace_fifo.
// Build with TRACE_TRIGGER_EN to exercise the trigger path.
module tb_cpu_trace_fifo;

  localparam int AW = 4;
`ifdef TRACE_TRIGGER_EN
  localparam logic [15:0] TIP = 16'h0005;
`else
  localparam logic [15:0] TIP = 16'h0000;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   i_jp;
  logic [15:0]   i_ip;
  logic [15:0]   i_cmd;
  logic          i_en;
  logic          i_clr;
  logic          i_ready;
  logic          o_valid;
  logic [31:0]   o_data;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic [15:0]   o_drop_cnt;

  int checks = 0;
  int errors = 0;

  cpu_trace_fifo #(
    .AW     (AW),
    .TRIG_IP(TIP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .i_jp      (i_jp),
    .i_ip      (i_ip),
    .i_cmd     (i_cmd),
    .i_en      (i_en),
    .i_clr     (i_clr),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_count   (o_count),
    .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [15:0] ip,
                       input logic [15:0] cmd);
    i_ip  = ip;
    i_cmd = cmd;
    i_jp  = 16'd1;
    tick();
    i_jp = 16'd2;
    tick();
    i_jp = 16'd0;
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    i_jp    = '0;
    i_ip    = '0;
    i_cmd   = '0;
    i_en    = 1'b1;
    i_clr   = 1'b0;
    i_ready = 1'b0;
    #2;
    chk("rst_count", 32'(o_count), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", o_data, 0);
    chk("rst_ovf", 32'(o_overflow), 0);
    chk("rst_drop", 32'(o_drop_cnt), 0);
    tick();
    reset = 1'b0;
    tick();

`ifdef TRACE_TRIGGER_EN
    for (int i = 0; i < 9; i++)
      fetch(16'(i), 16'h2000 + 16'(i));
    chk("trg_count", 32'(o_count), 4);
    chk("trg_head", o_data, 32'h0005_2005);
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    chk("trg_clr", 32'(o_count), 0);
    fetch(16'h0006, 16'h3333);
    chk("trg_rearm", 32'(o_count), 0);
    fetch(16'h0005, 16'h4444);
    chk("trg_again", 32'(o_count), 1);
    chk("trg_again_d", o_data, 32'h0005_4444);
`else
    // Fetch order and drain.
    fetch(16'h0000, 16'h1101);
    fetch(16'h0001, 16'h3001);
    fetch(16'h0002, 16'h0000);
    chk("ord_count", 32'(o_count), 3);
    chk("ord_valid", 32'(o_valid), 1);
    chk("ord_d0", o_data, 32'h0000_1101);
    i_ready = 1'b1;
    tick();
    chk("ord_d1", o_data, 32'h0001_3001);
    chk("ord_cnt2", 32'(o_count), 2);
    tick();
    chk("ord_d2", o_data, 32'h0002_0000);
    tick();
    chk("ord_empty", 32'(o_valid), 0);
    chk("ord_data0", o_data, 0);
    tick();
    chk("ord_rd_empty", 32'(o_count), 0);
    i_ready = 1'b0;

    // Stall at beat 1.
    i_ip  = 16'h0007;
    i_cmd = 16'hAAAA;
    i_jp  = 16'd1;
    repeat (5) tick();
    i_jp = 16'd0;
    tick();
    chk("stall_count", 32'(o_count), 1);
    chk("stall_data", o_data, 32'h0007_AAAA);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("stall_drain", 32'(o_count), 0);

    // Overflow.
    for (int i = 0; i < 20; i++)
      fetch(16'(i), 16'h1000 + 16'(i));
    chk("ovf_count", 32'(o_count), 16);
    chk("ovf_flag", 32'(o_overflow), 1);
    chk("ovf_drop", 32'(o_drop_cnt), 4);
    chk("ovf_head", o_data, 32'h0000_1000);

    // Full with simultaneous capture and read.
    i_ip    = 16'h0055;
    i_cmd   = 16'hBEEF;
    i_jp    = 16'd1;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    i_jp    = 16'd0;
    chk("fr_count", 32'(o_count), 16);
    chk("fr_drop", 32'(o_drop_cnt), 4);
    chk("fr_head", o_data, 32'h0001_1001);
    i_ready = 1'b1;
    repeat (15) tick();
    i_ready = 1'b0;
    chk("fr_last_cnt", 32'(o_count), 1);
    chk("fr_last", o_data, 32'h0055_BEEF);

    // Clear with coincident capture; jp_prev keeps tracking.
    i_clr = 1'b1;
    i_jp  = 16'd1;
    i_ip  = 16'h0020;
    tick();
    i_clr = 1'b0;
    chk("clr_count", 32'(o_count), 0);
    chk("clr_ovf", 32'(o_overflow), 0);
    chk("clr_drop", 32'(o_drop_cnt), 0);
    tick();
    i_jp = 16'd0;
    chk("clr_jpprev", 32'(o_count), 0);
    tick();

    // Async reset mid-drain.
    fetch(16'h0010, 16'h0001);
    fetch(16'h0011, 16'h0002);
    fetch(16'h0012, 16'h0003);
    i_ready = 1'b1;
    tick();
    chk("md_count", 32'(o_count), 2);
    reset = 1'b1;
    #1;
    chk("ar_count", 32'(o_count), 0);
    chk("ar_valid", 32'(o_valid), 0);
    chk("ar_data", o_data, 0);
    i_ready = 1'b0;
    i_ip    = 16'h0033;
    i_cmd   = 16'h4444;
    i_jp    = 16'd1;
    tick();
    reset = 1'b0;
    tick();
    i_jp = 16'd0;
    chk("ar_cap_cnt", 32'(o_count), 1);
    chk("ar_cap_data", o_data, 32'h0033_4444);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
